uart_tx_cfg: RTL



---
 rtl/uart_tx_cfg.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: LSB-first frames with optional parity and 1 or 2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input, which holds the line low while idle.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx_ready,
    output logic                 tx_active,
    output logic                 tx_done,
    output logic                 tx_serial
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_baud
        $error("uart_tx_cfg: CLKS_PER_BIT must be in 2..65535");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic                 par_q, par_n;
    logic                 ready_n, active_n, done_n, serial_n;
    logic                 bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_ready  <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            tx_serial <= 1'b1;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            shift_q   <= shift_n;
            par_q     <= par_n;
            tx_ready  <= ready_n;
            tx_active <= active_n;
            tx_done   <= done_n;
            tx_serial <= serial_n;
        end
    end

    // Outputs are computed for the next cycle so every port comes straight from a flop;
    // the counter only wraps at a bit boundary, which is also the only place the state moves.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        idx_n    = idx_q;
        shift_n  = shift_q;
        par_n    = par_q;
        ready_n  = tx_ready;
        active_n = tx_active;
        done_n   = 1'b0;
        serial_n = tx_serial;
        bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

        if (state_q != IDLE) begin
            cnt_n = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    serial_n = 1'b0;
                    ready_n  = 1'b0;
                    active_n = 1'b0;
                end else
`endif
                if (tx_valid && tx_ready) begin
                    state_n  = START;
                    shift_n  = tx_data;
                    par_n    = (PARITY_MODE == 1) ? ~(^tx_data) : ^tx_data;
                    serial_n = 1'b0;
                    ready_n  = 1'b0;
                    active_n = 1'b1;
                end else begin
                    serial_n = 1'b1;
                    ready_n  = 1'b1;
                    active_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n  = DATA;
                    idx_n    = '0;
                    serial_n = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_n = '0;
                        if (PARITY_MODE != 0) begin
                            state_n  = PARITY;
                            serial_n = par_q;
                        end else begin
                            state_n  = STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        idx_n    = idx_q + 1'b1;
                        shift_n  = shift_q >> 1;
                        serial_n = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n  = STOP;
                    idx_n    = '0;
                    serial_n = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_n  = IDLE;
                        idx_n    = '0;
                        done_n   = 1'b1;
                        ready_n  = 1'b1;
                        active_n = 1'b0;
                        serial_n = 1'b1;
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                serial_n = 1'b1;
                ready_n  = 1'b1;
                active_n = 1'b0;
            end
        endcase
    end

endmodule
